// File: rtl/phase_ramp_gen_v3.sv
// phase_ramp_gen_v3: FOG closed-loop phase-ramp generator with gain shift, 2pi wrap and modulation add.
module phase_ramp_gen_v3 #(
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 16,
  parameter int GAIN_W    = 5,
  parameter int GAIN_INIT = 5,
  parameter int CNT_W     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_mod_trig,
  input  logic [1:0]              i_mode,
  input  logic signed [ACC_W-1:0] i_step,
  input  logic signed [OUT_W-1:0] i_mod,
  input  logic [GAIN_W-1:0]       i_gain_sel,
  input  logic [OUT_W-2:0]        i_v2pi,
  output logic signed [OUT_W-1:0] o_phase_ramp,
  output logic signed [OUT_W-1:0] o_ramp,
  output logic                    o_wrap_pos,
  output logic                    o_wrap_neg,
  output logic [CNT_W-1:0]        o_wrap_cnt,
  output logic                    o_trig_drop,
  output logic                    o_busy
);
  typedef enum logic [2:0] {IDLE, SUM, WRAP, OUT, RESCALE} state_t;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [GAIN_W-1:0]       G_MAX   = GAIN_W'(ACC_W - OUT_W);
  localparam logic [GAIN_W-1:0]       G_INIT  = GAIN_W'(GAIN_INIT);

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_p_q, op_mode_q, op_mode_d;
  logic [GAIN_W-1:0]       gain_q, ga_q, ga_d, g, up, dn;
  logic signed [ACC_W-1:0] step_q, step_d, acc_q, acc_d, r, v2, wv, shl, acc_add;
  logic signed [OUT_W-1:0] mod_q, mod_d, ramp_q, ramp_d, phase_q, phase_d, ro, sat_out;
  logic [ACC_W:0]          acc_sum;
  logic [OUT_W:0]          out_sum;
  logic                    wp_q, wp_d, wn_q, wn_d, pos_q, pos_d, neg_q, neg_d;
  logic                    shl_ok, wrap_p, wrap_n, clr;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Gain is clamped so that i_v2pi << g always fits in ACC_W-1 bits.
  assign g       = gain_q > G_MAX ? G_MAX : gain_q;
  assign up      = g - ga_q;
  assign dn      = ga_q - g;
  assign r       = acc_q >>> ga_q;
  assign v2      = $signed({{(ACC_W-OUT_W+1){1'b0}}, i_v2pi});
  assign wv      = v2 <<< ga_q;
  assign wrap_p  = i_v2pi != '0 && r >= v2;
  assign wrap_n  = i_v2pi != '0 && r < -v2;
  assign acc_sum = {acc_q[ACC_W-1], acc_q} + {step_q[ACC_W-1], step_q};
  assign acc_add = (acc_sum[ACC_W] ^ acc_sum[ACC_W-1]) ? (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
  assign shl     = acc_q <<< up;
  assign shl_ok  = (shl >>> up) == acc_q;
  assign ro      = r[OUT_W-1:0];
  assign out_sum = {ro[OUT_W-1], ro} + {mod_q[OUT_W-1], mod_q};
  assign sat_out = (out_sum[OUT_W] ^ out_sum[OUT_W-1]) ? (out_sum[OUT_W] ? OUT_MIN : OUT_MAX) : out_sum[OUT_W-1:0];
  assign clr     = mode_q == 2'd0 && mode_p_q != 2'd0;

  always_comb begin
    state_d   = state_q;
    ga_d      = ga_q;
    op_mode_d = op_mode_q;
    step_d    = step_q;
    mod_d     = mod_q;
    acc_d     = acc_q;
    wp_d      = wp_q;
    wn_d      = wn_q;
    ramp_d    = ramp_q;
    phase_d   = phase_q;
    pos_d     = 1'b0;
    neg_d     = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_mod_trig) begin
          if (mode_q != 2'd3) begin
            state_d   = SUM;
            op_mode_d = mode_q;
            step_d    = i_step;
            mod_d     = i_mod;
          end
        end else if (g != ga_q) state_d = RESCALE;
      end
      SUM: begin
        acc_d   = op_mode_q == 2'd0 ? '0 : acc_add;
        state_d = WRAP;
      end
      WRAP: begin
        wp_d    = wrap_p;
        wn_d    = !wrap_p && wrap_n;
        acc_d   = wrap_p ? acc_q - wv : wrap_n ? acc_q + wv : acc_q;
        state_d = OUT;
      end
      OUT: begin
        ramp_d  = ro;
        phase_d = op_mode_q == 2'd1 ? sat_out : op_mode_q == 2'd2 ? ro : mod_q;
        pos_d   = wp_q;
        neg_d   = wn_q;
        cnt_d   = cnt_q + CNT_W'(wp_q) - CNT_W'(wn_q);
        state_d = IDLE;
      end
      RESCALE: begin
        acc_d   = g > ga_q ? (shl_ok ? shl : (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX)) : acc_q >>> dn;
        ga_d    = g;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      acc_d  = '0;
      ramp_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      mode_p_q  <= '0;
      gain_q    <= G_INIT;
      ga_q      <= G_INIT;
      op_mode_q <= '0;
      step_q    <= '0;
      mod_q     <= '0;
      acc_q     <= '0;
      wp_q      <= 1'b0;
      wn_q      <= 1'b0;
      ramp_q    <= '0;
      phase_q   <= '0;
      pos_q     <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= i_mode;
      mode_p_q  <= mode_q;
      gain_q    <= i_gain_sel;
      ga_q      <= ga_d;
      op_mode_q <= op_mode_d;
      step_q    <= step_d;
      mod_q     <= mod_d;
      acc_q     <= acc_d;
      wp_q      <= wp_d;
      wn_q      <= wn_d;
      ramp_q    <= ramp_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_phase_ramp = phase_q;
  assign o_ramp       = ramp_q;
  assign o_wrap_pos   = pos_q;
  assign o_wrap_neg   = neg_q;
  assign o_wrap_cnt   = cnt_q;
  assign o_trig_drop  = i_mod_trig && state_q != IDLE;
  assign o_busy       = state_q != IDLE;
endmodule

// File: tb/tb_phase_ramp_gen_v3.sv
// tb_phase_ramp_gen_v3: scoreboard bench; a monitor checks each completed update (3-cycle busy run).
module tb_phase_ramp_gen_v3;
  logic               clk, rst_n, trig_i, wp, wn, drop, busy;
  logic [1:0]         mode_i;
  logic signed [31:0] step_i;
  logic signed [15:0] mod_i, phase, ramp;
  logic [4:0]         gain_i;
  logic [14:0]        v2pi_i;
  logic [15:0]        cnt;

  typedef struct {
    logic signed [15:0] ramp;
    logic signed [15:0] phase;
    logic               wp;
    logic               wn;
    logic [15:0]        cnt;
  } exp_t;
  exp_t q[$];
  int n_chk, n_fail, drops, brun;

  phase_ramp_gen_v3 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mod_trig(trig_i), .i_mode(mode_i), .i_step(step_i),
    .i_mod(mod_i), .i_gain_sel(gain_i), .i_v2pi(v2pi_i), .o_phase_ramp(phase), .o_ramp(ramp),
    .o_wrap_pos(wp), .o_wrap_neg(wn), .o_wrap_cnt(cnt), .o_trig_drop(drop), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int r, int p, bit pos, bit neg, int c);
    exp_t e;
    e.ramp  = 16'(r);
    e.phase = 16'(p);
    e.wp    = pos;
    e.wn    = neg;
    e.cnt   = 16'(c);
    q.push_back(e);
  endtask

  task automatic trig(int s, int m);
    step_i = s;
    mod_i  = 16'(m);
    trig_i = 1'b1;
    @(posedge clk);
    #1 trig_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) brun = 0;
    else if (busy) brun++;
    else begin
      if (brun == 3) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_update: got ramp %0d, expected no update", ramp);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ramp", ramp, e.ramp);
          chk("phase", phase, e.phase);
          chk("wrap_pos", wp, e.wp);
          chk("wrap_neg", wn, e.wn);
          chk("wrap_cnt", cnt, e.cnt);
        end
      end
      brun = 0;
    end
    if (rst_n && drop) drops++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; trig_i = 1'b0; mode_i = 2'd1; step_i = 0; mod_i = 0; gain_i = 5'd5; v2pi_i = 15'd16000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ramp", ramp, 0);
    chk("rst_phase", phase, 0);
    chk("rst_wrap_pos", wp, 0);
    chk("rst_wrap_neg", wn, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i <= 15; i++) begin
      push(1000 * i, 1000 * i, 0, 0, 0);
      trig(32000, 0);
    end
    push(15000, 32767, 0, 0, 0);
    trig(0, 30000);
    push(15000, -15000, 0, 0, 0);
    trig(0, -30000);
    push(0, 0, 1, 0, 1);
    trig(32000, 0);
    // trigger at T+2 must be dropped, trigger at T+4 accepted
    push(1000, 1000, 0, 0, 1);
    step_i = 32000; mod_i = 0; trig_i = 1'b1;
    @(posedge clk);
    #1 trig_i = 1'b0;
    @(posedge clk);
    #1 trig_i = 1'b1;
    @(negedge clk);
    chk("trig_drop", drop, 1);
    @(posedge clk);
    #1 trig_i = 1'b0;
    @(posedge clk);
    #1;
    push(2000, 2000, 0, 0, 1);
    trig(32000, 0);
    for (int i = 3; i <= 10; i++) begin
      push(1000 * i, 1000 * i, 0, 0, 1);
      trig(32000, 0);
    end
    // acc = 320000: rescale to g=6 gives 640000, +32000 -> 672000 >>> 6 = 10500
    gain_i = 5'd6;
    repeat (6) @(posedge clk);
    #1;
    push(10500, 10500, 0, 0, 1);
    trig(32000, 0);
    gain_i = 5'd5;
    repeat (6) @(posedge clk);
    #1;
    push(11500, 11500, 0, 0, 1);
    trig(32000, 0);
    mode_i = 2'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mode0_clr_ramp", ramp, 0);
    chk("mode0_clr_cnt", cnt, 0);
    @(posedge clk);
    #1;
    push(0, 1234, 0, 0, 0);
    trig(0, 1234);
    mode_i = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 1; i <= 16; i++) begin
      push(-1000 * i, -1000 * i, 0, 0, 0);
      trig(-32000, 0);
    end
    push(-1000, -1000, 0, 1, 16'hFFFF);
    trig(-32000, 0);
    mode_i = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    repeat (3) trig(5000, 99);
    @(negedge clk);
    chk("mode3_ramp", ramp, -1000);
    chk("mode3_phase", phase, -1000);
    chk("mode3_busy", busy, 0);
    @(posedge clk);
    #1 mode_i = 2'd1;
    repeat (3) @(posedge clk);
    #1 step_i = 32000; mod_i = 0; trig_i = 1'b1;
    @(posedge clk);
    #1 trig_i = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ramp", ramp, 0);
    chk("midrst_phase", phase, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_update_ramp", ramp, 0);
    chk("queue_empty", q.size(), 0);
    chk("drop_count", drops, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
